// File: rtl/mem_cmd_sequencer_if.sv
// mem_cmd_sequencer_if: UART byte stream and bit-memory bus
// between the command sequencer and its surroundings.
interface mem_cmd_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              tx_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, tx_wait, mem_rdata,
    output tx_data, tx_we, mem_addr, mem_we,
    output mem_wdata, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_wait, mem_rdata,
    input  tx_data, tx_we, mem_addr, mem_we,
    input  mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: UART byte commands (W/R/D) turned into
// bit-memory writes, reads and single-byte replies.
module mem_cmd_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 2000000
) (
  input logic                 clk,
  input logic                 resetn,
  mem_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, A_HI, A_LO, ARG,
    WRITE, RD_ISSUE, RD_WAIT, TX
  } state_t;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] CH_Q = 8'h3F;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [7:0]        opcode;
  logic [7:0]        addr_hi;
  logic [7:0]        count;
  logic [ADDR_W-1:0] addr;
  logic              wdata;
  logic [7:0]        txd;
  logic              err_q;
  logic [31:0]       tcnt;

  logic        rx;
  logic        is_op;
  logic        waiting;
  logic        tmo;
  logic        drop;
  logic        more;
  logic [15:0] addr_full;

  assign rx        = bus.rx_valid;
  assign is_op     = bus.rx_data inside {OP_W, OP_R, OP_D};
  assign waiting   = state inside {A_HI, A_LO, ARG};
  assign tmo       = (TIMEOUT != 0) && waiting && !rx
                     && (tcnt == TO_LAST);
  assign drop      = rx && (state inside
                     {WRITE, RD_ISSUE, RD_WAIT, TX});
  assign more      = (opcode == OP_D) && (count != 8'd0);
  assign addr_full = {addr_hi, bus.rx_data};

  assign bus.tx_data   = txd;
  assign bus.tx_we     = (state == TX);
  assign bus.mem_addr  = addr;
  assign bus.mem_we    = (state == WRITE) && resetn;
  assign bus.mem_wdata = wdata;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // next-state: a received byte always beats a timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rx) state_nx = is_op ? A_HI : TX;
      end
      A_HI: begin
        if (rx)       state_nx = A_LO;
        else if (tmo) state_nx = IDLE;
      end
      A_LO: begin
        if (rx)
          state_nx = (opcode == OP_R) ? RD_ISSUE : ARG;
        else if (tmo)
          state_nx = IDLE;
      end
      ARG: begin
        if (rx)
          state_nx = (opcode == OP_W) ? WRITE : RD_ISSUE;
        else if (tmo)
          state_nx = IDLE;
      end
      WRITE:    state_nx = TX;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = TX;
      TX: begin
        if (!bus.tx_wait) state_nx = more ? RD_ISSUE : IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // operand capture, timeout counter, reply byte, error strobe
  always_ff @(posedge clk) begin
    if (!resetn) begin
      opcode  <= '0;
      addr_hi <= '0;
      count   <= '0;
      addr    <= '0;
      wdata   <= 1'b0;
      txd     <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      err_q <= drop || tmo;
      if (waiting) begin
        if (rx)                tcnt <= '0;
        else if (TIMEOUT != 0) tcnt <= tcnt + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (rx) begin
            opcode <= bus.rx_data;
            count  <= '0;
            tcnt   <= '0;
            if (!is_op) txd <= CH_Q;
          end
        end
        A_HI: begin
          if (rx) addr_hi <= bus.rx_data;
        end
        A_LO: begin
          if (rx) addr <= addr_full[ADDR_W-1:0];
        end
        ARG: begin
          if (rx) begin
            if (opcode == OP_W) wdata <= bus.rx_data[0];
            else                count <= bus.rx_data;
          end
        end
        WRITE:    txd <= CH_K;
        RD_ISSUE: ;
        RD_WAIT:  txd <= bus.mem_rdata ? CH_1 : CH_0;
        TX: begin
          if (!bus.tx_wait && more) begin
            count <= count - 8'd1;
            addr  <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// tb_mem_cmd_sequencer: random and directed commands checked
// against a transaction-level model of replies and writes.
module tb_mem_cmd_sequencer;

  localparam int AW = 16;
  localparam int TO = 100;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_D = 8'h44;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  mem_cmd_sequencer_if #(.ADDR_W(AW)) bus ();

  mem_cmd_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  bit ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  bit          ref_mem [0:(1<<AW)-1];
  logic [7:0]  exp_rep [$];
  logic [AW:0] exp_wr  [$];
  logic [7:0]  got_rep [$];
  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int err_exp = 0;
  int wait_fix = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic          last_wr_data = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // transmitter: hold tx_wait for wait_fix cycles per byte, or random
  initial begin
    int wcnt;
    int wlen;
    wcnt = 0;
    wlen = 0;
    bus.tx_wait = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_we) begin
        if (wcnt == 0)
          wlen = (wait_fix >= 0) ? wait_fix : $urandom_range(0, 4);
        bus.tx_wait = (wcnt < wlen);
        wcnt++;
      end else begin
        wcnt = 0;
        bus.tx_wait = 1'($urandom_range(0, 1));
      end
    end
  end

  // compare process
  initial begin
    logic p_we, p_acc, p_rst, p_mwe;
    logic [7:0] p_data;
    p_we = 0; p_acc = 0; p_rst = 1; p_mwe = 0; p_data = 0;
    forever begin
      @(negedge clk);
      if (resetn && p_we && !p_acc && !p_rst) begin
        chk("tx_hold", 32'(bus.tx_we), 32'd1);
        chk("tx_stable", 32'(bus.tx_data), 32'(p_data));
      end
      if (resetn && bus.tx_we && !bus.tx_wait) begin
        got_rep.push_back(bus.tx_data);
        if (exp_rep.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL reply_extra: got %02h, required none",
                   bus.tx_data);
        end else begin
          chk("reply", 32'(bus.tx_data), 32'(exp_rep.pop_front()));
        end
      end
      if (bus.mem_we) begin
        last_wr_addr = bus.mem_addr;
        last_wr_data = bus.mem_wdata;
        if (exp_wr.size() == 0 || p_mwe) begin
          tests++;
          fails++;
          $display("FAIL write_extra: got %04h/%0d, required none",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          chk("write", 32'({bus.mem_addr, bus.mem_wdata}),
              32'(exp_wr.pop_front()));
        end
      end
      if (bus.tx_we || bus.mem_we)
        chk("busy_active", 32'(bus.busy), 32'd1);
      if (bus.err) err_seen++;
      p_we   = bus.tx_we;
      p_acc  = bus.tx_we && !bus.tx_wait;
      p_data = bus.tx_data;
      p_rst  = !resetn;
      p_mwe  = bus.mem_we;
    end
  end

  // command-level model: what the block must reply and write
  function automatic void model_cmd(input logic [7:0] op,
                                    input logic [15:0] a,
                                    input logic [7:0] arg);
    logic [AW-1:0] ad;
    logic [AW-1:0] x;
    ad = a[AW-1:0];
    if (op == OP_W) begin
      exp_wr.push_back({ad, arg[0]});
      ref_mem[ad] = arg[0];
      exp_rep.push_back(8'h4B);
    end else if (op == OP_R) begin
      exp_rep.push_back(ref_mem[ad] ? 8'h31 : 8'h30);
    end else if (op == OP_D) begin
      for (int i = 0; i <= int'(arg); i++) begin
        x = ad + AW'(i);
        exp_rep.push_back(ref_mem[x] ? 8'h31 : 8'h30);
      end
    end else begin
      exp_rep.push_back(8'h3F);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic inject();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'($urandom);
    err_exp++;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_clear", 32'(bus.busy), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op,
                          input logic [15:0] a,
                          input logic [7:0] arg);
    send_byte(op);
    if (op inside {OP_W, OP_R, OP_D}) begin
      gap();
      send_byte(a[15:8]);
      gap();
      send_byte(a[7:0]);
      if (op != OP_R) begin
        gap();
        send_byte(arg);
      end
    end
  endtask

  // inj: 0 none, 1 random extra bytes, 2 one extra byte in TX
  task automatic do_cmd(input logic [7:0] op,
                        input logic [15:0] a,
                        input logic [7:0] arg,
                        input int inj);
    int n;
    model_cmd(op, a, arg);
    send_cmd(op, a, arg);
    if (inj == 1) begin
      repeat ($urandom_range(1, 2)) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (bus.busy) inject();
      end
    end else if (inj == 2) begin
      n = 0;
      while (!bus.tx_we && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("tx_reached", 32'(bus.tx_we), 32'd1);
      if (bus.tx_we) inject();
    end
    wait_idle();
    chk("err_count", 32'(err_seen), 32'(err_exp));
    chk("replies_left", 32'(exp_rep.size()), 32'd0);
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic seen_busy;
    logic [7:0] op;
    logic [15:0] a;
    logic [7:0] g;
    int r;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_we", 32'(bus.tx_we), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    wait_fix = 0;
    got_rep.delete();
    do_cmd(OP_W, 16'h0123, 8'h01, 0);
    chk("w_reply_cnt", 32'(got_rep.size()), 32'd1);
    chk("w_reply", 32'(got_rep[0]), 32'h4B);
    chk("w_addr", 32'(last_wr_addr), 32'h0123);
    chk("w_data", 32'(last_wr_data), 32'd1);

    got_rep.delete();
    do_cmd(OP_R, 16'h0123, 8'h00, 0);
    chk("r_one", 32'(got_rep[0]), 32'h31);
    do_cmd(OP_W, 16'h0123, 8'hFE, 0);
    got_rep.delete();
    do_cmd(OP_R, 16'h0123, 8'h00, 0);
    chk("r_zero", 32'(got_rep[0]), 32'h30);

    do_cmd(OP_W, 16'hFFFE, 8'h01, 0);
    do_cmd(OP_W, 16'hFFFF, 8'h00, 0);
    do_cmd(OP_W, 16'h0000, 8'h01, 0);
    do_cmd(OP_W, 16'h0001, 8'h03, 0);
    wait_fix = 50;
    got_rep.delete();
    do_cmd(OP_D, 16'hFFFE, 8'h03, 0);
    chk("d_cnt", 32'(got_rep.size()), 32'd4);
    chk("d_fffe", 32'(got_rep[0]), 32'h31);
    chk("d_ffff", 32'(got_rep[1]), 32'h30);
    chk("d_0000", 32'(got_rep[2]), 32'h31);
    chk("d_0001", 32'(got_rep[3]), 32'h31);

    wait_fix = 0;
    got_rep.delete();
    do_cmd(8'h41, 16'h0000, 8'h00, 0);
    chk("q_cnt", 32'(got_rep.size()), 32'd1);
    chk("q_reply", 32'(got_rep[0]), 32'h3F);

    // timeout after W + address high byte
    got_rep.delete();
    send_byte(OP_W);
    send_byte(8'h01);
    k = 0;
    seen_busy = 1'b0;
    while (k < 150 && !bus.err) begin
      if (k == 99) seen_busy = bus.busy;
      @(posedge clk);
      #1;
      k++;
    end
    err_exp++;
    chk("timeout_cycle", 32'(k), 32'd100);
    chk("busy_pre_timeout", 32'(seen_busy), 32'd1);
    chk("busy_post_timeout", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("err_single", 32'(bus.err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_err_cnt", 32'(err_seen), 32'(err_exp));
    chk("timeout_no_reply", 32'(got_rep.size()), 32'd0);

    // byte arriving exactly in the timeout cycle is taken
    model_cmd(OP_W, 16'h0A0B, 8'h01);
    send_byte(OP_W);
    repeat (98) @(posedge clk);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h01);
    wait_idle();
    chk("edge_err_cnt", 32'(err_seen), 32'(err_exp));
    chk("edge_replies", 32'(exp_rep.size()), 32'd0);
    chk("edge_writes", 32'(exp_wr.size()), 32'd0);

    wait_fix = 3;
    got_rep.delete();
    do_cmd(OP_W, 16'h0777, 8'h01, 2);
    chk("k_once", 32'(got_rep.size()), 32'd1);

    // reset in the middle of a dump
    wait_fix = 50;
    got_rep.delete();
    model_cmd(OP_D, 16'h0120, 8'h05);
    send_cmd(OP_D, 16'h0120, 8'h05);
    k = 0;
    while (!bus.tx_we && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("dump_tx", 32'(bus.tx_we), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_rep.delete();
    @(posedge clk);
    #1;
    chk("abort_tx_we", 32'(bus.tx_we), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort_tx_data", 32'(bus.tx_data), 32'd0);
    resetn = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("abort_no_reply", 32'(got_rep.size()), 32'd0);
    wait_fix = 0;
    got_rep.delete();
    do_cmd(OP_R, 16'h0121, 8'h00, 0);
    chk("after_rst", 32'(got_rep.size()), 32'd1);

    do_cmd(OP_D, 16'hFF80, 8'hFF, 0);

    wait_fix = -1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = OP_W;
      else if (r < 6) op = OP_R;
      else if (r < 9) op = OP_D;
      else begin
        op = 8'($urandom_range(0, 255));
        while (op inside {OP_W, OP_R, OP_D})
          op = 8'($urandom_range(0, 255));
      end
      case ($urandom_range(0, 2))
        0:       a = 16'($urandom);
        1:       a = 16'hFFF0 | 16'($urandom_range(0, 15));
        default: a = 16'($urandom_range(0, 31));
      endcase
      if (op == OP_D) g = 8'($urandom_range(0, 12));
      else            g = 8'($urandom);
      do_cmd(op, a, g, ($urandom_range(0, 9) < 3) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
